// File: rtl/sine_pkg.sv
// Shared types and constants for the Sine ctrl_saxi configuration sequencer.
package sine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD,
    ST_RD_DATA,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RESP     = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  function automatic logic [31:0] cfg_word(input logic [127:0] words, input logic [1:0] idx);
    return words[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/sine_cfg_sequencer_if.sv
// AXI4-Lite bundle (32-bit address/data) between the sequencer and the Sine register slave.
interface sine_cfg_sequencer_if;

  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/sine_cfg_sequencer.sv
// Writes C_NUM_REGS config words to the Sine ctrl_saxi block over AXI4-Lite,
// reads each one back for verification, and reports done or a coded error.
module sine_cfg_sequencer
  import sine_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_NUM_REGS  = 4,
  parameter int unsigned C_TIMEOUT   = 255
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        start,
  input  logic [127:0]                cfg_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_index,
  output logic [1:0]                  err_code,
  sine_cfg_sequencer_if.master        M_AXI
);

  localparam logic [1:0] LAST_IDX    = 2'(C_NUM_REGS - 1);
  localparam logic [7:0] TIMEOUT_LIM = 8'(C_TIMEOUT);

  seq_state_e   state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [127:0] shadow_q, shadow_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         awvalid_q, awvalid_d;
  logic         wvalid_q, wvalid_d;
  logic         bready_q, bready_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         error_q, error_d;
  logic [1:0]   err_index_q, err_index_d;
  logic [1:0]   err_code_q, err_code_d;

  logic         fail;
  logic [1:0]   fail_code;
  logic         aw_done, w_done, timeout;
  logic [31:0]  reg_addr;
  logic [31:0]  cur_word;

  assign reg_addr = C_BASE_ADDR + {28'd0, idx_q, 2'b00};
  assign cur_word = cfg_word(shadow_q, idx_q);
  assign timeout  = (cnt_q == TIMEOUT_LIM);

  assign M_AXI.AWADDR  = reg_addr;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.AWVALID = awvalid_q;
  assign M_AXI.WDATA   = cur_word;
  assign M_AXI.WSTRB   = '1;
  assign M_AXI.WVALID  = wvalid_q;
  assign M_AXI.BREADY  = bready_q;
  assign M_AXI.ARADDR  = reg_addr;
  assign M_AXI.ARPROT  = 3'b000;
  assign M_AXI.ARVALID = arvalid_q;
  assign M_AXI.RREADY  = rready_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign err_code  = err_code_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    fail        = 1'b0;
    fail_code   = ERR_NONE;
    aw_done     = !awvalid_q || M_AXI.AWREADY;
    w_done      = !wvalid_q || M_AXI.WREADY;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d    = cfg_data;
          err_code_d  = ERR_NONE;
          err_index_d = '0;
          idx_d       = '0;
          busy_d      = 1'b1;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          state_d     = ST_WR;
        end
      end
      ST_WR: begin
        if (awvalid_q && M_AXI.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI.WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI.BVALID) begin
          bready_d = 1'b0;
          if (M_AXI.BRESP == AXI_OKAY || M_AXI.BRESP == AXI_EXOKAY) begin
            arvalid_d = 1'b1;
            state_d   = ST_RD;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      ST_RD: begin
        if (M_AXI.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      ST_RD_DATA: begin
        // The index advance is folded into the read-data accept so a
        // zero-wait slave costs 4 cycles per register, not 5.
        if (M_AXI.RVALID) begin
          rready_d = 1'b0;
          if (M_AXI.RRESP != AXI_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else if (M_AXI.RDATA != cur_word) begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d     = idx_q + 2'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      state_d     = ST_ERR;
      error_d     = 1'b1;
      err_code_d  = fail_code;
      err_index_d = idx_q;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 8'd1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_sine_cfg_sequencer.sv
// Directed bench for sine_cfg_sequencer against a small AXI4-Lite register slave
// with programmable W latency, AR stall, write-response error and readback corruption.
module tb_sine_cfg_sequencer;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         start;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_index, err_code;

  sine_cfg_sequencer_if axi();

  sine_cfg_sequencer #(
    .C_BASE_ADDR (32'h0000_0000),
    .C_NUM_REGS  (4),
    .C_TIMEOUT   (255)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .start     (start),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .err_code  (err_code),
    .M_AXI     (axi)
  );

  always #5 ACLK = ~ACLK;

  // Slave knobs
  int w_lat         = 0;
  bit ar_block      = 1'b0;
  int bresp_err_idx = -1;
  int corrupt_idx   = -1;

  // Slave state
  logic [31:0] mem [4];
  int          w_wait;
  bit          aw_have, w_have;
  logic [31:0] aw_addr_s, w_data_s;
  int          wr_count, ar_count;

  assign axi.AWREADY = axi.AWVALID;
  assign axi.WREADY  = axi.WVALID && (w_wait >= w_lat);
  assign axi.ARREADY = axi.ARVALID && !ar_block;

  always @(posedge ACLK or posedge ARESET) begin : slave
    bit          a_h, d_h;
    logic [31:0] a, d;
    if (ARESET) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      w_wait    <= 0;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      aw_addr_s <= '0;
      w_data_s  <= '0;
      wr_count  <= 0;
      ar_count  <= 0;
      axi.BVALID <= 1'b0;
      axi.BRESP  <= 2'b00;
      axi.RVALID <= 1'b0;
      axi.RRESP  <= 2'b00;
      axi.RDATA  <= '0;
    end else begin
      a_h = aw_have;
      d_h = w_have;
      a   = aw_addr_s;
      d   = w_data_s;
      if (axi.AWVALID && axi.AWREADY) begin
        a_h = 1'b1;
        a   = axi.AWADDR;
      end
      if (axi.WVALID && axi.WREADY) begin
        d_h = 1'b1;
        d   = axi.WDATA;
        w_wait <= 0;
      end else if (axi.WVALID) begin
        w_wait <= w_wait + 1;
      end
      if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
      if (a_h && d_h) begin
        mem[a[3:2]] <= d;
        wr_count    <= wr_count + 1;
        axi.BVALID  <= 1'b1;
        axi.BRESP   <= (int'(a[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
        a_h = 1'b0;
        d_h = 1'b0;
      end
      aw_have   <= a_h;
      w_have    <= d_h;
      aw_addr_s <= a;
      w_data_s  <= d;
      if (axi.ARVALID && axi.ARREADY) begin
        axi.RVALID <= 1'b1;
        axi.RRESP  <= 2'b00;
        axi.RDATA  <= mem[axi.ARADDR[3:2]] ^
                      ((int'(axi.ARADDR[3:2]) == corrupt_idx) ? 32'h0000_0001 : 32'h0);
        ar_count   <= ar_count + 1;
      end else if (axi.RVALID && axi.RREADY) begin
        axi.RVALID <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Pulse start; returns sampled just after the edge that accepted it.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges until done or error; optionally re-pulses start at poke_at.
  task automatic run_until(input int max_cyc, input int poke_at, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      step();
      cyc++;
      start = (cyc == poke_at);
      if (done || error) break;
    end
    start = 1'b0;
  endtask

  function automatic logic [4:0] hs_bits();
    return {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY};
  endfunction

  localparam logic [127:0] CFG_A = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff};
  localparam logic [127:0] CFG_B = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int wr0, ar0;
    start    = 1'b0;
    cfg_data = CFG_A;
    ARESET   = 1'b0;
    #2 ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    step();

    // Reset state
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done_err", {done, error}, 2'b00);
    check_eq("rst_err_code", err_code, 2'b00);
    check_eq("rst_err_index", err_index, 2'b00);
    check_eq("rst_handshake", hs_bits(), 5'b00000);

    // Zero-wait slave, full sequence; mid-run start with new cfg must be ignored
    kick();
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_aw_w_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
    check_eq("t1_awaddr0", axi.AWADDR, 32'h0);
    check_eq("t1_wdata0", axi.WDATA, 32'h0101ffff);
    cfg_data = '0;
    run_until(40, 5, cyc);
    check_eq("t1_done_latency", cyc, 16);
    check_eq("t1_done", {done, error}, 2'b10);
    check_eq("t1_mem0", mem[0], 32'h0101ffff);
    check_eq("t1_mem1", mem[1], 32'habcd0001);
    check_eq("t1_mem2", mem[2], 32'hdead0011);
    check_eq("t1_mem3", mem[3], 32'hbeef0011);
    check_eq("t1_writes", wr_count, 4);
    check_eq("t1_reads", ar_count, 4);
    step();
    check_eq("t1_done_pulse", done, 1'b0);
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_err_code", err_code, 2'b00);

    // AWREADY three cycles ahead of WREADY
    cfg_data = CFG_A;
    w_lat    = 3;
    wr0      = wr_count;
    kick();
    check_eq("t2_both_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
    step();
    check_eq("t2_aw_drops_alone", {axi.AWVALID, axi.WVALID}, 2'b01);
    step();
    step();
    check_eq("t2_w_held", {axi.AWVALID, axi.WVALID}, 2'b01);
    step();
    check_eq("t2_w_done", {axi.WVALID, axi.BREADY}, 2'b01);
    check_eq("t2_single_write", wr_count - wr0, 1);
    run_until(60, -1, cyc);
    check_eq("t2_done_latency", cyc, 24);
    check_eq("t2_done", done, 1'b1);
    check_eq("t2_writes", wr_count - wr0, 4);
    w_lat = 0;
    step();

    // SLVERR on register 2 write
    bresp_err_idx = 2;
    ar0 = ar_count;
    kick();
    run_until(40, -1, cyc);
    check_eq("t3_err_latency", cyc, 10);
    check_eq("t3_error", {done, error}, 2'b01);
    check_eq("t3_err_index", err_index, 2'd2);
    check_eq("t3_err_code", err_code, 2'b01);
    check_eq("t3_no_ar", ar_count - ar0, 2);
    check_eq("t3_handshake_idle", hs_bits(), 5'b00000);
    step();
    check_eq("t3_err_pulse", {error, busy}, 2'b00);
    check_eq("t3_err_latched", {err_index, err_code}, 4'b10_01);
    bresp_err_idx = -1;

    // Readback corruption on register 1
    corrupt_idx = 1;
    kick();
    check_eq("t4_err_cleared", {err_index, err_code}, 4'b00_00);
    run_until(40, -1, cyc);
    check_eq("t4_err_latency", cyc, 8);
    check_eq("t4_error", error, 1'b1);
    check_eq("t4_err_index", err_index, 2'd1);
    check_eq("t4_err_code", err_code, 2'b10);
    corrupt_idx = -1;
    step();

    // ARREADY stuck low -> timeout
    ar_block = 1'b1;
    kick();
    run_until(400, -1, cyc);
    check_eq("t5_err_latency", cyc, 258);
    check_eq("t5_error", error, 1'b1);
    check_eq("t5_err_code", err_code, 2'b11);
    check_eq("t5_err_index", err_index, 2'd0);
    check_eq("t5_arvalid", axi.ARVALID, 1'b0);
    ar_block = 1'b0;
    step();

    // Reset during WR_RESP, then a clean restart
    cfg_data = CFG_B;
    kick();
    step();
    check_eq("t6_in_wr_resp", axi.BREADY, 1'b1);
    ARESET = 1'b1;
    #1;
    check_eq("t6_rst_handshake", hs_bits(), 5'b00000);
    check_eq("t6_rst_status", {busy, done, error, err_index, err_code}, 7'b0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    check_eq("t6_rst_held", {busy, hs_bits()}, 6'b0);
    step();
    kick();
    check_eq("t6_restart_addr", axi.AWADDR, 32'h0);
    check_eq("t6_restart_wdata", axi.WDATA, 32'h44444444);
    run_until(40, -1, cyc);
    check_eq("t6_done_latency", cyc, 16);
    check_eq("t6_done", {done, error}, 2'b10);
    check_eq("t6_mem0", mem[0], 32'h44444444);
    check_eq("t6_mem3", mem[3], 32'h11111111);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
